uart_ev_arbiter: RTL
====================

Name: uart_ev_arbiter

Overview:
- Shares the single UART event packer between N_CH timestamper channels.
- Round-robin grants one pending channel event at a time and latches it into a registered output slot.
- Stamps each event with an ID built from the channel index and a global wrapping sequence number.
- Presents the event to the packer on a valid/ready handshake and holds it until the packer accepts.

Parameters:
- N_CH, 4, number of requesting timestamper channels (2..16).
- TS_W, 64, timestamp width of start/end/delta.
- ID_W, 16, output event ID width; must satisfy ID_W > CH_W.
- CH_W, $clog2(N_CH) (min 1), channel-index field width, derived.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- ch_en  in  N_CH  per-channel enable mask; bit i = 0 blocks channel i from being granted.
- ch_valid  in  N_CH  per-channel event pending.
- ch_ready  out  N_CH  one-hot accept pulse to the granted channel.
- ch_start  in  N_CH*TS_W  packed start timestamps, channel i at [i*TS_W +: TS_W].
- ch_end  in  N_CH*TS_W  packed end timestamps.
- ch_delta  in  N_CH*TS_W  packed deltas.
- ev_valid  out  1  event slot valid, to packer.
- ev_ready  in  1  packer accepts the event.
- ev_id  out  ID_W  {channel index (CH_W MSBs), seq[ID_W-CH_W-1:0]}.
- ev_start, ev_end, ev_delta  out  TS_W each  latched event payload.
- seq_count  out  ID_W-CH_W  events delivered so far, wrapping.

Behaviour:
- Reset (rst = 0, async):
  - state = IDLE, rr_ptr = 0, seq = 0, ev_valid = 0, ch_ready = 0.
  - ev_id, ev_start, ev_end and ev_delta = 0.
- FSM has two states, IDLE and HOLD.
- IDLE:
  - req = ch_valid & ch_en.
  - If req != 0, grant g = the first set bit of req searching upward from rr_ptr, wrapping modulo N_CH.
  - ch_ready[g] = 1 combinationally in the same cycle; all other ch_ready bits = 0. This cycle is the channel handshake.
  - At the clock edge: latch payload of channel g, ev_id <= {g, seq}, ev_valid <= 1, state <= HOLD.
  - If req == 0: ch_ready = 0 and state stays IDLE.
- HOLD:
  - ch_ready = 0.
  - ev_valid = 1 and the payload is held stable, regardless of ch_valid/ch_en changes.
  - On ev_valid & ev_ready at the edge: ev_valid <= 0, seq <= seq + 1 (wraps at 2^(ID_W-CH_W)), rr_ptr <= (g + 1) mod N_CH, state <= IDLE.
- Latency and throughput:
  - ch_valid to ev_valid is 1 cycle.
  - There is one mandatory IDLE bubble after every packer handshake, so peak rate is 1 event per 2 cycles. This is far above the packer rate of 56 bytes per event.
- Fairness: with all channels continuously requesting, grants rotate 0,1,2,...,N_CH-1,0. No channel waits more than N_CH grants.
- Boundary conditions:
  - Disabling a channel (ch_en bit cleared) while its event is in HOLD does not cancel it; the event is still delivered.
  - A disabled channel never sees ch_ready.
  - ch_valid that drops in IDLE before a grant is not an error; the channel simply loses its turn.
  - A channel dropping ch_valid with ch_ready high is an upstream protocol violation; behaviour is undefined, and the bench asserts on it.
  - seq wraps from all-ones to 0 with no flag.
  - ev_ready asserted while ev_valid = 0 is ignored.
  - Reset mid-HOLD discards the held event; seq and rr_ptr return to 0.
  - ch_ready is at most one-hot in every cycle.
  - ch_ready is never asserted in HOLD.

Test Plan:
- Single event: N_CH=4, ch_valid=0001, ev_ready=1, start=0x10, end=0x30, delta=0x20.
  - Expect ch_ready=0001 for 1 cycle; next cycle ev_valid=1, ev_id=0x0000, payload matches.
  - After handshake, seq_count=1.
- Backpressure: ev_ready=0 for 60 cycles after ev_valid rises.
  - Expect ev_valid and payload stable, ch_ready=0 throughout.
  - Release ev_ready: handshake in 1 cycle, then IDLE.
- Round-robin: all four channels continuously valid, ev_ready=1.
  - Expect grant order 0,1,2,3,0,1.
  - Expect ev_id sequence 0x0000, 0x4001, 0x8002, 0xC003, 0x0004, 0x4005.
  - Expect 2 cycles between handshakes.
- Mask: ch_en=1010, all channels valid.
  - Expect only channels 1 and 3 granted, alternating.
  - Clear ch_en[3] during a HOLD on channel 3: that event is still delivered with ev_id channel field = 3.
- Wrap: preload by delivering 16384 events (ID_W=16, CH_W=2).
  - Expect seq_count returns to 0 and the next ev_id low field = 0.
- Async reset mid-HOLD: drive rst=0 between clock edges.
  - Expect ev_valid=0 and ch_ready=0 immediately.
  - After release with channel 2 valid: grant goes to channel 2 with ev_id=0x8000.

Source files
------------

// File: rtl/uart_ev_arbiter.sv
// rtl/uart_ev_arbiter.sv - round-robin arbiter feeding timestamper events to the shared UART packer
module uart_ev_arbiter #(
    parameter int N_CH = 4,
    parameter int TS_W = 64,
    parameter int ID_W = 16,
    parameter int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_CH-1:0]        ch_en,
    input  logic [N_CH-1:0]        ch_valid,
    output logic [N_CH-1:0]        ch_ready,
    input  logic [N_CH*TS_W-1:0]   ch_start,
    input  logic [N_CH*TS_W-1:0]   ch_end,
    input  logic [N_CH*TS_W-1:0]   ch_delta,
    output logic                   ev_valid,
    input  logic                   ev_ready,
    output logic [ID_W-1:0]        ev_id,
    output logic [TS_W-1:0]        ev_start,
    output logic [TS_W-1:0]        ev_end,
    output logic [TS_W-1:0]        ev_delta,
    output logic [ID_W-CH_W-1:0]   seq_count
);

    localparam int SEQ_W = ID_W - CH_W;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [CH_W-1:0]     rr_ptr;
    logic [CH_W-1:0]     grant;
    logic [CH_W-1:0]     cand;
    logic                grant_vld;
    logic [N_CH-1:0]     req;
    logic [SEQ_W-1:0]    seq;

    // (a + k) mod N_CH for a < N_CH, k < N_CH; one extra bit covers the pre-wrap sum
    function automatic logic [CH_W-1:0] wrap_add(input logic [CH_W-1:0] a, input int k);
        logic [CH_W:0] s;
        s = {1'b0, a} + (CH_W+1)'(k);
        if (s >= (CH_W+1)'(N_CH))
            s = s - (CH_W+1)'(N_CH);
        return s[CH_W-1:0];
    endfunction

    always_comb begin
        req       = ch_valid & ch_en;
        grant     = '0;
        cand      = '0;
        grant_vld = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            cand = wrap_add(rr_ptr, k);
            if (!grant_vld && req[cand]) begin
                grant     = cand;
                grant_vld = 1'b1;
            end
        end
    end

    // ch_ready is gated by rst so an asynchronous reset silences it immediately
    always_comb begin
        state_nxt = state;
        ch_ready  = '0;
        case (state)
            IDLE: begin
                if (grant_vld) begin
                    if (rst)
                        ch_ready = {{(N_CH-1){1'b0}}, 1'b1} << grant;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (ev_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            seq      <= '0;
            ev_id    <= '0;
            ev_start <= '0;
            ev_end   <= '0;
            ev_delta <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && grant_vld) begin
                ev_id    <= {grant, seq};
                ev_start <= ch_start[grant*TS_W +: TS_W];
                ev_end   <= ch_end[grant*TS_W +: TS_W];
                ev_delta <= ch_delta[grant*TS_W +: TS_W];
            end
            // the held event's channel lives in the ev_id MSBs
            if (state == HOLD && ev_ready) begin
                seq    <= seq + 1'b1;
                rr_ptr <= wrap_add(ev_id[ID_W-1 -: CH_W], 1);
            end
        end
    end

    assign ev_valid  = (state == HOLD);
    assign seq_count = seq;

endmodule
